lfsr_stream_checker: RTL and testbench



---
 rtl/lfsr_stream_checker.sv | 90 +++++++++
 tb/tb_lfsr_stream_checker.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: locks onto a 4-bit Fibonacci LFSR word stream, flywheels its prediction, counts mismatches
module lfsr_stream_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse
);
    typedef enum logic {SEARCH, LOCKED} state_t;
    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
    state_t state, state_n;
    logic have_prev, have_prev_n, err_n, wrap_n;
    logic [3:0] prev, prev_n, run, run_n, bad, bad_n, expected, expected_n;
    logic [ERR_W-1:0] cnt_n;
    function automatic logic [3:0] pred(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[0]};
    endfunction
    function automatic logic [3:0] inc4(input logic [3:0] x);
        return (x == 4'hf) ? x : x + 4'd1;
    endfunction
    // next-state: SEARCH counts consecutive correct transitions, LOCKED free-runs its own prediction
    always_comb begin
        state_n     = state;
        have_prev_n = have_prev;
        prev_n      = prev;
        run_n       = run;
        bad_n       = bad;
        expected_n  = expected;
        err_n       = 1'b0;
        wrap_n      = 1'b0;
        if (in_valid) begin
            if (state == SEARCH) begin
                run_n       = (in_data != 4'd0 && have_prev && in_data == pred(prev)) ? inc4(run) : 4'd0;
                have_prev_n = in_data != 4'd0;
                prev_n      = (in_data != 4'd0) ? in_data : prev;
                if (run_n == LOCK_N) begin
                    state_n    = LOCKED;
                    expected_n = pred(in_data);
                    bad_n      = 4'd0;
                end
            end else begin
                expected_n = pred(expected);
                err_n      = in_data != expected;
                wrap_n     = !err_n && in_data == 4'd1;
                bad_n      = err_n ? inc4(bad) : 4'd0;
                if (bad_n == LOSS_N) begin
                    state_n     = SEARCH;
                    run_n       = 4'd0;
                    have_prev_n = 1'b0;
                end
            end
        end
        cnt_n = clear_cnt ? ERR_W'(err_n) : (err_n && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
    end
    // registered state and outputs; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            have_prev  <= 1'b0;
            prev       <= 4'd0;
            run        <= 4'd0;
            bad        <= 4'd0;
            expected   <= 4'd1;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            have_prev  <= have_prev_n;
            prev       <= prev_n;
            run        <= run_n;
            bad        <= bad_n;
            expected   <= expected_n;
            locked     <= state_n == LOCKED;
            err_pulse  <= err_n;
            wrap_pulse <= wrap_n;
            err_count  <= cnt_n;
        end
    end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: table plus scoreboard check of lfsr_stream_checker at ERR_W=8 and ERR_W=2
module tb_lfsr_stream_checker;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear_cnt = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic locked, err_pulse, wrap_pulse, locked2, err_pulse2, wrap_pulse2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    int checks = 0, failures = 0, ec = 0;
    logic [3:0] w;
    typedef struct {logic l, e, w; int c;} exp_t;
    typedef struct {logic [3:0] d; logic l, e, w;} vec_t;
    exp_t sb[$];
    vec_t tbl[16];

    lfsr_stream_checker dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .wrap_pulse(wrap_pulse));
    lfsr_stream_checker #(.ERR_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
        .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .wrap_pulse(wrap_pulse2));

    always #5 clk = ~clk;

    function automatic logic [3:0] pred(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[0]};
    endfunction

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic clr,
                        input logic el, input logic ee, input logic ew, input int c);
        exp_t x;
        rst = r; in_valid = v; in_data = d; clear_cnt = clr;
        sb.push_back('{el, ee, ew, c});
        @(posedge clk); #1;
        x = sb.pop_front();
        chk("locked", int'(locked), int'(x.l));
        chk("err_pulse", int'(err_pulse), int'(x.e));
        chk("wrap_pulse", int'(wrap_pulse), int'(x.w));
        chk("err_count", int'(err_count), x.c);
        chk("locked_w2", int'(locked2), int'(x.l));
        chk("err_pulse_w2", int'(err_pulse2), int'(x.e));
        chk("err_count_w2", int'(err_count2), x.c > 3 ? 3 : x.c);
        rst = 1'b0; in_valid = 1'b0; in_data = 4'($urandom); clear_cnt = 1'b0;
    endtask

    task automatic lock_seq();
        ec = 0;
        step(1, 1, 4'b0101, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0001, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0111, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1111, 0, 1, 0, 0, 0);
        w = 4'b1110;
    endtask

    task automatic good();
        step(0, 1, w, 0, 1, 0, w == 4'd1, ec);
        w = pred(w);
    endtask

    task automatic miss();
        ec++;
        step(0, 1, 4'd0, 0, 1, 1, 0, ec);
        w = pred(w);
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 0, 0, 0};
        tbl[1]  = '{4'b0011, 0, 0, 0};
        tbl[2]  = '{4'b0111, 0, 0, 0};
        tbl[3]  = '{4'b1111, 1, 0, 0};
        tbl[4]  = '{4'b1110, 1, 0, 0};
        tbl[5]  = '{4'b1101, 1, 0, 0};
        tbl[6]  = '{4'b1010, 1, 0, 0};
        tbl[7]  = '{4'b0101, 1, 0, 0};
        tbl[8]  = '{4'b1011, 1, 0, 0};
        tbl[9]  = '{4'b0110, 1, 0, 0};
        tbl[10] = '{4'b1100, 1, 0, 0};
        tbl[11] = '{4'b1001, 1, 0, 0};
        tbl[12] = '{4'b0010, 1, 0, 0};
        tbl[13] = '{4'b0100, 1, 0, 0};
        tbl[14] = '{4'b1000, 1, 0, 0};
        tbl[15] = '{4'b0001, 1, 0, 1};
        step(1, 0, 4'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            step(0, 1, tbl[i].d, 0, tbl[i].l, tbl[i].e, tbl[i].w, 0);
        step(1, 0, 4'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0)
                for (int g = 0; g < 3; g++)
                    step(0, 0, 4'($urandom), 0, tbl[i-1].l, 0, 0, 0);
            step(0, 1, tbl[i].d, 0, tbl[i].l, tbl[i].e, tbl[i].w, 0);
        end
        lock_seq();
        miss();
        good();
        good();
        good();
        lock_seq();
        step(0, 1, 4'b1010, 0, 1, 1, 0, 1);
        step(0, 1, 4'b1010, 0, 0, 1, 0, 2);
        step(0, 1, 4'b0011, 0, 0, 0, 0, 2);
        step(0, 1, 4'b0111, 0, 0, 0, 0, 2);
        step(0, 1, 4'b1111, 0, 0, 0, 0, 2);
        step(0, 1, 4'b1110, 0, 1, 0, 0, 2);
        ec = 2;
        w = 4'b1101;
        ec = 0;
        step(0, 1, w, 1, 1, 0, w == 4'd1, 0);
        w = pred(w);
        for (int i = 0; i < 6; i++) begin
            miss();
            good();
        end
        ec = 1;
        step(0, 1, 4'd0, 1, 1, 1, 0, 1);
        w = pred(w);
        ec = 0;
        step(0, 0, 4'd5, 1, 1, 0, 0, 0);
        good();
        lock_seq();
        for (int i = 0; i < 5; i++) begin
            miss();
            good();
        end
        ec = 0;
        step(1, 1, w, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1101, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1010, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0101, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1011, 0, 1, 0, 0, 0);
        step(0, 1, 4'b0110, 0, 1, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
